control_unit_irq: RTL

Parametrised next-generation control FSM for the 8-bit Natalius-class core. It decodes the 16-bit instruction and drives the register file, ALU/shifter, PC, call stack and I/O port strobes. Additions over the base controller:
- configurable program-address width;
- I/O wait-state handshake with timeout;
- one maskable vectored interrupt with flag save/restore;
- RETI, EI and DI instructions.

---
 rtl/control_unit_irq.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_irq.sv
// Control FSM for the 8-bit Natalius-class core.
// Adds I/O wait states with timeout, one vectored IRQ, and RETI/EI/DI.
module control_unit_irq #(
  parameter int          ADDR_W   = 11,
  parameter logic [10:0] IRQ_VEC  = 11'h001,
  parameter int          WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  input  logic              z,
  input  logic              c,
  input  logic              irq,
  input  logic              io_ready,
  input  logic [ADDR_W-1:0] stack_addr,
  output logic [7:0]        port_addr,
  output logic              read_e,
  output logic              write_e,
  output logic              insel,
  output logic              we,
  output logic              selk,
  output logic              selimm,
  output logic              ldflag,
  output logic [2:0]        raa,
  output logic [2:0]        rab,
  output logic [2:0]        wa,
  output logic [2:0]        opalu,
  output logic [2:0]        sh,
  output logic              selpc,
  output logic              ldpc,
  output logic [ADDR_W-1:0] naddress,
  output logic [7:0]        KTE,
  output logic [7:0]        imm,
  output logic              wr_en,
  output logic              rd_en,
  output logic              irq_ack,
  output logic              ie,
  output logic              io_timeout,
  output logic              flag_rest,
  output logic              zs,
  output logic              cs
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, IO_WAIT, IRQ
  } state_t;

  localparam logic [4:0] OP_LDI  = 5'd2;
  localparam logic [4:0] OP_LDM  = 5'd3;
  localparam logic [4:0] OP_STM  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_JMP  = 5'd11;
  localparam logic [4:0] OP_JZ   = 5'd12;
  localparam logic [4:0] OP_JNZ  = 5'd13;
  localparam logic [4:0] OP_JC   = 5'd14;
  localparam logic [4:0] OP_JNC  = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd16;
  localparam logic [4:0] OP_RET  = 5'd17;
  localparam logic [4:0] OP_ADI  = 5'd18;
  localparam logic [4:0] OP_CZ   = 5'd19;
  localparam logic [4:0] OP_CNZ  = 5'd20;
  localparam logic [4:0] OP_CC   = 5'd21;
  localparam logic [4:0] OP_CNC  = 5'd22;
  localparam logic [4:0] OP_SH0  = 5'd23;
  localparam logic [4:0] OP_SH1  = 5'd24;
  localparam logic [4:0] OP_SH2  = 5'd25;
  localparam logic [4:0] OP_SH3  = 5'd26;
  localparam logic [4:0] OP_SH4  = 5'd27;
  localparam logic [4:0] OP_SH5  = 5'd28;
  localparam logic [4:0] OP_NOT  = 5'd29;
  localparam logic [4:0] OP_RETI = 5'd30;
  localparam logic [4:0] OP_EIDI = 5'd31;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);
  localparam logic [ADDR_W-1:0] VEC = IRQ_VEC[ADDR_W-1:0];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ie_d, zs_d, cs_d;
  logic              taken, is_ldm, is_io;
  logic              rr, rs;
  logic [4:0]        op;
  logic [2:0]        fa, fb;
  logic [7:0]        lit;
  logic [ADDR_W-1:0] tgt;

  assign op     = instruction[15:11];
  assign fa     = instruction[10:8];
  assign fb     = instruction[7:5];
  assign lit    = instruction[7:0];
  assign tgt    = instruction[ADDR_W-1:0];
  assign is_ldm = (op == OP_LDM);
  assign is_io  = is_ldm || (op == OP_STM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ie      <= 1'b0;
      zs      <= 1'b0;
      cs      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ie      <= ie_d;
      zs      <= zs_d;
      cs      <= cs_d;
    end
  end

  // Branch/call condition; unconditional forms share the same slot
  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (op == OP_JMP) || (op == OP_CALL): taken = 1'b1;
      (op == OP_JZ)  || (op == OP_CZ):   taken = z;
      (op == OP_JNZ) || (op == OP_CNZ):  taken = ~z;
      (op == OP_JC)  || (op == OP_CC):   taken = c;
      (op == OP_JNC) || (op == OP_CNC):  taken = ~c;
      default:                           taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ie_d    = ie;
    zs_d    = zs;
    cs_d    = cs;
    case (state_q)
      FETCH:  state_d = (ie && irq) ? IRQ : DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        if (is_io && !io_ready) begin
          state_d = IO_WAIT;
          cnt_d   = 8'd1;
        end
        if (op == OP_RETI) ie_d = 1'b1;
        if (op == OP_EIDI) ie_d = instruction[0];
      end
      IO_WAIT: begin
        if (io_ready || cnt_q == WMAX) begin
          state_d = FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IRQ: begin
        state_d = FETCH;
        ie_d    = 1'b0;
        zs_d    = z;
        cs_d    = c;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    port_addr  = '0;
    read_e     = 1'b0;
    write_e    = 1'b0;
    insel      = 1'b0;
    we         = 1'b0;
    selk       = 1'b0;
    selimm     = 1'b0;
    ldflag     = 1'b0;
    raa        = '0;
    rab        = '0;
    wa         = '0;
    opalu      = 3'd4;
    sh         = 3'd4;
    selpc      = 1'b0;
    ldpc       = 1'b1;
    naddress   = '0;
    KTE        = '0;
    imm        = '0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    irq_ack    = 1'b0;
    io_timeout = 1'b0;
    flag_rest  = 1'b0;
    rr         = 1'b0;
    rs         = 1'b0;
    case (state_q)
      FETCH: ldpc = 1'b0;
      DECODE: begin
        ldpc = 1'b0;
        case (op)
          OP_STM: begin
            raa       = fa;
            port_addr = lit;
          end
          OP_LDM: begin
            wa        = fa;
            port_addr = lit;
          end
          OP_RET, OP_RETI: rd_en = 1'b1;
          default: ;
        endcase
      end
      EXEC: begin
        case (op)
          OP_LDI: begin
            selk = 1'b1;
            KTE  = lit;
            we   = 1'b1;
            wa   = fa;
          end
          OP_ADD: begin rr = 1'b1; opalu = 3'd5; end
          OP_SUB: begin rr = 1'b1; opalu = 3'd6; end
          OP_AND: begin rr = 1'b1; opalu = 3'd1; end
          OP_OR:  begin rr = 1'b1; opalu = 3'd3; end
          OP_XOR: begin rr = 1'b1; opalu = 3'd2; end
          OP_CMP: begin
            ldflag = 1'b1;
            opalu  = 3'd6;
            raa    = fa;
            rab    = fb;
          end
          OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
            if (taken) begin
              naddress = tgt;
              selpc    = 1'b1;
            end
          end
          OP_CALL, OP_CZ, OP_CNZ, OP_CC, OP_CNC: begin
            if (taken) begin
              naddress = tgt;
              selpc    = 1'b1;
              wr_en    = 1'b1;
            end
          end
          OP_RET: begin
            naddress = stack_addr;
            selpc    = 1'b1;
          end
          OP_RETI: begin
            naddress  = stack_addr;
            selpc     = 1'b1;
            flag_rest = 1'b1;
          end
          OP_ADI: begin
            raa    = fa;
            wa     = fa;
            imm    = lit;
            selimm = 1'b1;
            insel  = 1'b1;
            opalu  = 3'd5;
            we     = 1'b1;
          end
          OP_SH0: begin rs = 1'b1; sh = 3'd0; end
          OP_SH1: begin rs = 1'b1; sh = 3'd5; end
          OP_SH2: begin rs = 1'b1; sh = 3'd2; end
          OP_SH3: begin rs = 1'b1; sh = 3'd6; end
          OP_SH4: begin rs = 1'b1; sh = 3'd1; end
          OP_SH5: begin rs = 1'b1; sh = 3'd3; end
          OP_NOT: opalu = 3'd0;
          OP_LDM: begin
            read_e    = 1'b1;
            port_addr = lit;
            wa        = fa;
            we        = io_ready;
            ldpc      = io_ready;
          end
          OP_STM: begin
            write_e   = 1'b1;
            port_addr = lit;
            raa       = fa;
            ldpc      = io_ready;
          end
          default: ;
        endcase
        if (rr) begin
          raa   = fa;
          wa    = fa;
          rab   = fb;
          insel = 1'b1;
          we    = 1'b1;
        end
        if (rs) begin
          raa   = fa;
          wa    = fa;
          insel = 1'b1;
          we    = 1'b1;
        end
      end
      IO_WAIT: begin
        port_addr = lit;
        read_e    = is_ldm;
        write_e   = ~is_ldm;
        ldpc      = 1'b0;
        if (is_ldm) wa = fa;
        else        raa = fa;
        // io_ready takes priority over an expiring counter
        if (io_ready) begin
          ldpc = 1'b1;
          we   = is_ldm;
        end else if (cnt_q == WMAX) begin
          io_timeout = 1'b1;
          ldpc       = 1'b1;
        end
      end
      IRQ: begin
        naddress = VEC;
        selpc    = 1'b1;
        wr_en    = 1'b1;
        irq_ack  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
